uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
- Sits between the UART Rx stack and N command consumers (DIM consumer and siblings).
- On each completed frame it broadcasts a one-clock frame_done to enabled consumers, then round-robin arbitrates the stack's single random ASCII read port among them.
- It waits until every enabled consumer drops busy, or a timeout expires, then pulses frame_release so the stack may accept the next frame.
- Frames arriving while a frame is in progress are dropped and counted.

Parameters:
- N_CONS, 4, number of consumers (2..8).
- MAX_FIELDS, 8, stack field count; W_F = clog2(MAX_FIELDS).
- MAX_FIELD_LEN, 16, stack field length; W_L = clog2(MAX_FIELD_LEN).
- TIMEOUT_CYC, 4096, maximum S_RUN cycles per frame (>= 4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- frame_done_in  in  1  stack frame-complete pulse
- frame_release  out  1  one-clock pulse; stack may overwrite the frame
- cons_enable  in  N_CONS  consumer enable mask; sampled at dispatch
- cons_frame_done  out  N_CONS  one-clock dispatch pulse, one bit per consumer
- cons_busy  in  N_CONS  consumer parse_busy
- cons_rd_req  in  N_CONS  read request; held until ack
- cons_rd_field  in  N_CONS*W_F  per-consumer field address, consumer i at [i*W_F +: W_F]
- cons_rd_index  in  N_CONS*W_L  per-consumer char index
- cons_rd_ack  out  N_CONS  one-clock read-data-valid, one-hot
- cons_rd_char  out  8  broadcast read data, meaningful with ack
- cons_rd_char_valid  out  1  broadcast stack valid, meaningful with ack
- rd_field  out  W_F  stack read field
- rd_index  out  W_L  stack read index
- rd_char  in  8  stack data; registered read, valid 1 clk after address
- rd_char_valid  in  1  stack valid, same timing as rd_char
- seq_busy  out  1  high whenever state != S_IDLE
- err_timeout  out  1  one-clock pulse on timeout
- frame_drop  out  1  one-clock pulse on dropped frame
- drop_count  out  16  saturating count of dropped frames

Behaviour:
- Reset: all outputs 0, drop_count 0, state S_IDLE, round-robin pointer 0, no read in flight.
  - Reset asserted mid-frame abandons the frame; no release pulse is issued.
- S_IDLE: on frame_done_in, latch en_q = cons_enable and drive cons_frame_done <= cons_enable (visible next clk).
  - If cons_enable == 0: go to S_RELEASE.
  - Otherwise: go to S_WAIT.
- S_WAIT: one cycle so consumers can raise busy; go to S_RUN with timeout counter cleared.
- S_RUN:
  - Count cycles.
  - Exit to S_RELEASE when no read is in flight and (cons_busy & en_q) == 0.
  - If the counter reaches TIMEOUT_CYC-1: pulse err_timeout and go to S_RELEASE; an in-flight read is dropped with no ack.
- S_RELEASE: pulse frame_release; go to S_IDLE.
- Read arbitration (S_RUN only; requests outside S_RUN or from bits with en_q=0 are ignored):
  - Cycle R: no read in flight and req & en_q != 0. Grant the first requester at or after the pointer. Register its field/index onto rd_field/rd_index; mark in flight. Pointer becomes winner+1 mod N_CONS.
  - Cycle R+1: stack presents address.
  - Cycle R+2: cons_rd_ack[winner] = 1; cons_rd_char and cons_rd_char_valid pass rd_char/rd_char_valid through combinationally. In-flight clears.
  - Next grant may issue in cycle R+2 (registered), so throughput is 1 read per 2 clks.
  - Per-request latency is 2 clks uncontended; worst case 2*N_CONS.
  - A requester that drops req while its read is in flight still gets ack; it ignores it.
  - rd_field/rd_index hold their last value between grants.
- frame_done_in in any state other than S_IDLE, including S_RELEASE: pulse frame_drop; drop_count increments and saturates at 16'hFFFF.
- Consumer busy still high at release after a timeout is ignored. The next frame dispatches normally.

Decomposition:
- Package uart_pkg: clog2 function, state encodings (S_IDLE=0, S_WAIT=1, S_RUN=2, S_RELEASE=3), default widths for MAX_FIELDS/MAX_FIELD_LEN.
- One sub-module: rr_arbiter
  - Inputs: N-way request vector, pointer.
  - Output: one-hot grant.
  - Pointer advances only when a grant is accepted.

Test Plan:
- Single consumer, enable=0001: frame_done_in at t0 -> cons_frame_done[0] at t1; consumer reads "DIM" at index 0..2 -> each ack 2 clks after req with chars 0x44/0x49/0x4D; busy low -> frame_release once, seq_busy low after.
- Two consumers request simultaneously, pointer 0 -> grants 0,1,0,1 alternate; each ack one-hot; no ack lost; rd_field/rd_index match granted consumer.
- Consumer holds busy forever, TIMEOUT_CYC=16 -> err_timeout at the 16th S_RUN cycle, frame_release on the next clk.
- frame_done_in pulsed during S_RUN and again in S_RELEASE -> two frame_drop pulses, drop_count=2, no extra dispatch. With drop_count preloaded near max (65535 drops) -> stays at 0xFFFF.
- cons_enable=0000 -> frame_release 2 clks after frame_done_in; no cons_frame_done. Disabled consumer's rd_req is never granted.
- rst_n low for 1 clk mid-read in S_RUN -> all outputs 0 on the next clk; no ack, no release; next frame proceeds normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared helpers, sequencer state encoding and default stack geometry for the UART command path.
package uart_pkg;

    localparam int unsigned DEF_MAX_FIELDS    = 8;
    localparam int unsigned DEF_MAX_FIELD_LEN = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } seq_state_e;

    // Elaboration-time only; returns 0 for values <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic [PW:0] idx;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            // Scan positions ptr, ptr+1, ... wrapping modulo N.
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                gnt_idx          = idx[PW-1:0];
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Dispatches each completed UART frame to enabled consumers, arbitrates the stack read port
// among them and releases the frame once all consumers are idle or a timeout expires.
module uart_cmd_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned N_CONS        = 4,
    parameter int unsigned MAX_FIELDS    = DEF_MAX_FIELDS,
    parameter int unsigned MAX_FIELD_LEN = DEF_MAX_FIELD_LEN,
    parameter int unsigned TIMEOUT_CYC   = 4096,
    localparam int unsigned W_F = clog2(MAX_FIELDS),
    localparam int unsigned W_L = clog2(MAX_FIELD_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_done_in,
    output logic                    frame_release,
    input  logic [N_CONS-1:0]       cons_enable,
    output logic [N_CONS-1:0]       cons_frame_done,
    input  logic [N_CONS-1:0]       cons_busy,
    input  logic [N_CONS-1:0]       cons_rd_req,
    input  logic [N_CONS*W_F-1:0]   cons_rd_field,
    input  logic [N_CONS*W_L-1:0]   cons_rd_index,
    output logic [N_CONS-1:0]       cons_rd_ack,
    output logic [7:0]              cons_rd_char,
    output logic                    cons_rd_char_valid,
    output logic [W_F-1:0]          rd_field,
    output logic [W_L-1:0]          rd_index,
    input  logic [7:0]              rd_char,
    input  logic                    rd_char_valid,
    output logic                    seq_busy,
    output logic                    err_timeout,
    output logic                    frame_drop,
    output logic [15:0]             drop_count
);

    localparam int unsigned PW = clog2(N_CONS);
    localparam int unsigned TW = clog2(TIMEOUT_CYC);

    seq_state_e        state_q, state_d;
    logic [N_CONS-1:0] en_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     win_q;
    logic              inflight_q;
    logic [N_CONS-1:0] ack_q;
    logic [TW-1:0]     cnt_q;
    logic [W_F-1:0]    rd_field_q;
    logic [W_L-1:0]    rd_index_q;
    logic [N_CONS-1:0] cons_frame_done_q;
    logic              frame_release_q;
    logic              err_timeout_q;
    logic              frame_drop_q;
    logic [15:0]       drop_count_q;

    logic              run;
    logic              done_ok;
    logic              timeout_hit;
    logic              grant_fire;
    logic              drop_evt;
    logic [N_CONS-1:0] gnt;
    logic [PW-1:0]     gnt_idx;
    logic [W_F-1:0]    sel_field;
    logic [W_L-1:0]    sel_index;

    assign run         = (state_q == S_RUN);
    assign done_ok     = run && !inflight_q && ((cons_busy & en_q) == '0);
    // A clean finish on the last allowed cycle wins over the timeout.
    assign timeout_hit = run && !done_ok && (cnt_q == TW'(TIMEOUT_CYC - 1));
    assign grant_fire  = run && !inflight_q && !done_ok && !timeout_hit && (gnt != '0);
    assign drop_evt    = frame_done_in && (state_q != S_IDLE);

    rr_arbiter #(
        .N (N_CONS)
    ) u_arb (
        .req     (cons_rd_req & en_q),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_field = '0;
        sel_index = '0;
        for (int i = 0; i < N_CONS; i++) begin
            if (gnt[i]) begin
                sel_field = sel_field | cons_rd_field[i*W_F +: W_F];
                sel_index = sel_index | cons_rd_index[i*W_L +: W_L];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_done_in) begin
                    state_d = (cons_enable == '0) ? S_RELEASE : S_WAIT;
                end
            end
            S_WAIT:    state_d = S_RUN;
            S_RUN: begin
                if (done_ok || timeout_hit) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        seq_busy    = (state_q != S_IDLE);
        cons_rd_ack = ack_q;
        if (ack_q != '0) begin
            cons_rd_char       = rd_char;
            cons_rd_char_valid = rd_char_valid;
        end else begin
            cons_rd_char       = 8'h00;
            cons_rd_char_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q              <= '0;
            ptr_q             <= '0;
            win_q             <= '0;
            inflight_q        <= 1'b0;
            ack_q             <= '0;
            cnt_q             <= '0;
            rd_field_q        <= '0;
            rd_index_q        <= '0;
            cons_frame_done_q <= '0;
            frame_release_q   <= 1'b0;
            err_timeout_q     <= 1'b0;
            frame_drop_q      <= 1'b0;
            drop_count_q      <= '0;
        end else begin
            cons_frame_done_q <= '0;
            frame_release_q   <= (state_q == S_RELEASE);
            err_timeout_q     <= timeout_hit;
            frame_drop_q      <= drop_evt;
            if (drop_evt && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            if ((state_q == S_IDLE) && frame_done_in) begin
                en_q              <= cons_enable;
                cons_frame_done_q <= cons_enable;
            end
            if (state_q == S_WAIT) begin
                cnt_q <= '0;
            end else if (run && !timeout_hit) begin
                cnt_q <= cnt_q + TW'(1);
            end
            // Stack data is valid two cycles after the grant; a timeout discards it.
            ack_q      <= '0;
            inflight_q <= 1'b0;
            if (run && inflight_q && !timeout_hit) begin
                ack_q <= N_CONS'(1) << win_q;
            end
            if (grant_fire) begin
                inflight_q <= 1'b1;
                win_q      <= gnt_idx;
                rd_field_q <= sel_field;
                rd_index_q <= sel_index;
                ptr_q      <= (gnt_idx == PW'(N_CONS - 1)) ? '0 : gnt_idx + PW'(1);
            end
        end
    end

    assign cons_frame_done = cons_frame_done_q;
    assign frame_release   = frame_release_q;
    assign err_timeout     = err_timeout_q;
    assign frame_drop      = frame_drop_q;
    assign drop_count      = drop_count_q;
    assign rd_field        = rd_field_q;
    assign rd_index        = rd_index_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a registered-read stack model.
module tb_uart_cmd_sequencer;

    localparam int unsigned N   = 4;
    localparam int unsigned W_F = 3;
    localparam int unsigned W_L = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_done_in;
    logic             frame_release;
    logic [N-1:0]     cons_enable;
    logic [N-1:0]     cons_frame_done;
    logic [N-1:0]     cons_busy;
    logic [N-1:0]     cons_rd_req;
    logic [N*W_F-1:0] cons_rd_field;
    logic [N*W_L-1:0] cons_rd_index;
    logic [N-1:0]     cons_rd_ack;
    logic [7:0]       cons_rd_char;
    logic             cons_rd_char_valid;
    logic [W_F-1:0]   rd_field;
    logic [W_L-1:0]   rd_index;
    logic [7:0]       rd_char = 8'h00;
    logic             rd_char_valid = 1'b0;
    logic             seq_busy;
    logic             err_timeout;
    logic             frame_drop;
    logic [15:0]      drop_count;

    int n_chk  = 0;
    int n_pass = 0;

    uart_cmd_sequencer #(
        .N_CONS        (N),
        .MAX_FIELDS    (8),
        .MAX_FIELD_LEN (16),
        .TIMEOUT_CYC   (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .frame_done_in      (frame_done_in),
        .frame_release      (frame_release),
        .cons_enable        (cons_enable),
        .cons_frame_done    (cons_frame_done),
        .cons_busy          (cons_busy),
        .cons_rd_req        (cons_rd_req),
        .cons_rd_field      (cons_rd_field),
        .cons_rd_index      (cons_rd_index),
        .cons_rd_ack        (cons_rd_ack),
        .cons_rd_char       (cons_rd_char),
        .cons_rd_char_valid (cons_rd_char_valid),
        .rd_field           (rd_field),
        .rd_index           (rd_index),
        .rd_char            (rd_char),
        .rd_char_valid      (rd_char_valid),
        .seq_busy           (seq_busy),
        .err_timeout        (err_timeout),
        .frame_drop         (frame_drop),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    // Field 0 holds "DIM"; other fields hold 0x20 + {field, index}.
    function automatic logic [7:0] stack_char(input logic [2:0] f, input logic [3:0] i);
        if (f == 3'd0) begin
            case (i)
                4'd0:    return 8'h44;
                4'd1:    return 8'h49;
                4'd2:    return 8'h4D;
                default: return 8'h00;
            endcase
        end
        return 8'h20 + {1'b0, f, i};
    endfunction

    always @(posedge clk) begin
        rd_char       <= stack_char(rd_field, rd_index);
        rd_char_valid <= (rd_field != 3'd0) || (rd_index < 4'd3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic set_addr(input int c, input int f, input int i);
        cons_rd_field[c*W_F +: W_F] = 3'(f);
        cons_rd_index[c*W_L +: W_L] = 4'(i);
    endtask

    initial begin
        rst_n = 1'b0; frame_done_in = 1'b0; cons_enable = '0; cons_busy = '0;
        cons_rd_req = '0; cons_rd_field = '0; cons_rd_index = '0;
        tick(); tick();
        check("rst_release", frame_release, 0);
        check("rst_busy", seq_busy, 0);
        check("rst_cfd", cons_frame_done, 0);
        check("rst_ack", cons_rd_ack, 0);
        check("rst_drops", drop_count, 0);
        check("rst_addr", {rd_field, rd_index}, 0);
        check("rst_char", cons_rd_char, 0);
        rst_n = 1'b1;

        // Two consumers contending, pointer starts at 0.
        cons_enable = 4'b0011; frame_done_in = 1'b1;
        tick();
        check("rr_dispatch", cons_frame_done, 4'b0011);
        check("rr_seq_busy", seq_busy, 1);
        frame_done_in = 1'b0; cons_busy = 4'b0011;
        tick();
        check("rr_cfd_pulse", cons_frame_done, 0);
        set_addr(0, 1, 2); set_addr(1, 3, 5); cons_rd_req = 4'b0011;
        tick();
        check("rr_addr_a", {rd_field, rd_index}, {3'd1, 4'd2});
        check("rr_noack_a", cons_rd_ack, 0);
        tick();
        check("rr_ack_a", cons_rd_ack, 4'b0001);
        check("rr_char_a", cons_rd_char, 8'h32);
        set_addr(0, 2, 0);
        tick();
        check("rr_addr_b", {rd_field, rd_index}, {3'd3, 4'd5});
        check("rr_noack_b", cons_rd_ack, 0);
        tick();
        check("rr_ack_b", cons_rd_ack, 4'b0010);
        check("rr_char_b", cons_rd_char, 8'h55);
        set_addr(1, 4, 1);
        tick();
        check("rr_addr_c", {rd_field, rd_index}, {3'd2, 4'd0});
        tick();
        check("rr_ack_c", cons_rd_ack, 4'b0001);
        check("rr_char_c", cons_rd_char, 8'h40);
        cons_rd_req = 4'b0010;
        tick();
        check("rr_addr_d", {rd_field, rd_index}, {3'd4, 4'd1});
        tick();
        check("rr_ack_d", cons_rd_ack, 4'b0010);
        check("rr_char_d", cons_rd_char, 8'h61);
        cons_rd_req = '0; cons_busy = '0;
        tick();
        check("rr_rel_early", frame_release, 0);
        tick();
        check("rr_release", frame_release, 1);
        check("rr_idle", seq_busy, 0);
        tick();

        // Single consumer reads "DIM" plus one past the end.
        cons_enable = 4'b0001; frame_done_in = 1'b1;
        tick();
        check("dim_dispatch", cons_frame_done, 4'b0001);
        frame_done_in = 1'b0; cons_busy = 4'b0001;
        tick();
        set_addr(0, 0, 0); cons_rd_req = 4'b0001;
        tick();
        check("dim_noack", cons_rd_ack, 0);
        tick();
        check("dim_ack0", cons_rd_ack, 4'b0001);
        check("dim_D", cons_rd_char, 8'h44);
        check("dim_valid0", cons_rd_char_valid, 1);
        set_addr(0, 0, 1);
        tick(); tick();
        check("dim_I", cons_rd_char, 8'h49);
        set_addr(0, 0, 2);
        tick(); tick();
        check("dim_M", cons_rd_char, 8'h4D);
        set_addr(0, 0, 3);
        tick(); tick();
        check("dim_ack3", cons_rd_ack, 4'b0001);
        check("dim_valid3", cons_rd_char_valid, 0);
        cons_rd_req = '0; cons_busy = '0;
        tick();
        check("dim_rel_early", frame_release, 0);
        tick();
        check("dim_release", frame_release, 1);
        check("dim_idle", seq_busy, 0);
        tick();
        check("dim_rel_once", frame_release, 0);

        // Frames arriving in S_RUN and S_RELEASE are dropped.
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0; cons_busy = 4'b0001;
        tick(); tick(); tick();
        frame_done_in = 1'b1;
        tick();
        check("drop_run", frame_drop, 1);
        check("drop_cnt1", drop_count, 1);
        frame_done_in = 1'b0; cons_busy = '0;
        tick();
        check("drop_pulse", frame_drop, 0);
        frame_done_in = 1'b1;
        tick();
        check("drop_rel", frame_drop, 1);
        check("drop_cnt2", drop_count, 2);
        check("drop_release", frame_release, 1);
        check("drop_no_cfd", cons_frame_done, 0);
        frame_done_in = 1'b0;
        tick();
        check("drop_no_dispatch", seq_busy, 0);
        check("drop_cnt_hold", drop_count, 2);

        // Empty enable mask releases two clocks after the frame.
        cons_enable = 4'b0000; frame_done_in = 1'b1;
        tick();
        check("en0_cfd", cons_frame_done, 0);
        check("en0_rel_early", frame_release, 0);
        frame_done_in = 1'b0;
        tick();
        check("en0_release", frame_release, 1);
        tick();

        // Requests from a disabled consumer are ignored.
        cons_enable = 4'b0001; frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0; cons_busy = 4'b0001;
        tick();
        set_addr(2, 5, 7); cons_rd_req = 4'b0100;
        tick(); tick();
        check("dis_noack_a", cons_rd_ack, 0);
        tick(); tick();
        check("dis_noack_b", cons_rd_ack, 0);
        check("dis_addr", {rd_field, rd_index}, {3'd0, 4'd3});
        cons_rd_req = '0; cons_busy = '0;
        tick(); tick();
        check("dis_release", frame_release, 1);

        // Busy held forever: timeout after 16 S_RUN cycles drops the in-flight read.
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0; cons_busy = 4'b0001;
        tick();
        repeat (14) tick();
        set_addr(0, 1, 1); cons_rd_req = 4'b0001;
        tick();
        check("to_grant", {rd_field, rd_index}, {3'd1, 4'd1});
        check("to_not_yet", err_timeout, 0);
        tick();
        check("to_err", err_timeout, 1);
        check("to_no_ack", cons_rd_ack, 0);
        check("to_rel_early", frame_release, 0);
        cons_rd_req = '0;
        tick();
        check("to_release", frame_release, 1);
        check("to_err_pulse", err_timeout, 0);
        check("to_idle", seq_busy, 0);

        // Reset in the middle of a read.
        frame_done_in = 1'b1;
        tick();
        check("rr2_dispatch", cons_frame_done, 4'b0001);
        frame_done_in = 1'b0;
        tick();
        set_addr(0, 0, 1); cons_rd_req = 4'b0001;
        tick();
        rst_n = 1'b0;
        tick();
        check("mr_ack", cons_rd_ack, 0);
        check("mr_busy", seq_busy, 0);
        check("mr_release", frame_release, 0);
        check("mr_drops", drop_count, 0);
        check("mr_addr", {rd_field, rd_index}, 0);
        check("mr_err", err_timeout, 0);
        rst_n = 1'b1; cons_rd_req = '0; cons_busy = '0;
        tick();
        check("mr_ack_after", cons_rd_ack, 0);
        check("mr_rel_after", frame_release, 0);
        tick();
        check("mr_rel_after2", frame_release, 0);
        frame_done_in = 1'b1;
        tick();
        check("mr_next_cfd", cons_frame_done, 4'b0001);
        frame_done_in = 1'b0; cons_busy = 4'b0001;
        tick();
        set_addr(0, 0, 2); cons_rd_req = 4'b0001;
        tick(); tick();
        check("mr_next_ack", cons_rd_ack, 4'b0001);
        check("mr_next_char", cons_rd_char, 8'h4D);
        cons_rd_req = '0; cons_busy = '0;
        tick(); tick();
        check("mr_next_release", frame_release, 1);

        // Continuous frames with a stuck-busy consumer: 18 drops per 19-cycle frame.
        cons_busy = 4'b0001; frame_done_in = 1'b1;
        repeat (190) tick();
        check("sat_mid", drop_count, 180);
        repeat (69300) tick();
        check("sat_max", drop_count, 16'hFFFF);
        tick();
        check("sat_hold", drop_count, 16'hFFFF);
        frame_done_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
